// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte-serial instruction fetch with ready handshake, timeout and abort
module instr_fetch #(
  parameter int ADR_W   = 8,
  parameter int NBYTES  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ADR_W-1:0] pc,
  output logic             mem_rd,
  output logic [ADR_W-1:0] mem_adr,
  input  logic             mem_ready,
  input  logic [7:0]       mem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  output logic             busy,
  output logic             error
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [7:0] WCNT_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [ADR_W-1:0] base, base_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       wcnt, wcnt_nxt;
  logic [31:0]      shadow, shadow_nxt;
  logic [31:0]      instr_nxt;
  logic             error_nxt;
  logic             launch;

  // a start is only honoured outside FETCH, and abort always wins
  assign launch = start && !abort && (state != FETCH);

  always_comb begin
    state_nxt  = state;
    base_nxt   = base;
    idx_nxt    = idx;
    wcnt_nxt   = wcnt;
    shadow_nxt = shadow;
    instr_nxt  = instr;
    error_nxt  = error;
    if (abort) begin
      state_nxt = IDLE;
      error_nxt = 1'b0;
    end else if (launch) begin
      state_nxt = FETCH;
      base_nxt  = pc;
      idx_nxt   = '0;
      wcnt_nxt  = '0;
      error_nxt = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            for (int i = 0; i < 4; i++) begin
              if (idx == IDX_W'(i)) shadow_nxt[8*i +: 8] = mem_rdata;
            end
            wcnt_nxt = '0;
            if (idx == LAST_IDX) begin
              idx_nxt   = '0;
              state_nxt = DONE;
              instr_nxt = shadow_nxt;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else if (wcnt == WCNT_MAX) begin
            state_nxt = ERR;
            error_nxt = 1'b1;
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
        DONE:    state_nxt = IDLE;
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      base   <= '0;
      idx    <= '0;
      wcnt   <= '0;
      shadow <= '0;
      instr  <= '0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      base   <= base_nxt;
      idx    <= idx_nxt;
      wcnt   <= wcnt_nxt;
      shadow <= shadow_nxt;
      instr  <= instr_nxt;
      error  <= error_nxt;
    end
  end

  assign mem_rd      = (state == FETCH);
  assign busy        = (state == FETCH);
  assign instr_valid = (state == DONE);
  assign mem_adr     = base + ADR_W'(idx);
  assign opcode      = instr[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a byte-array memory model
module tb_instr_fetch;

  logic        clk, reset, start, abort, mem_rd, mem_ready, instr_valid, busy, error;
  logic [7:0]  pc, mem_adr, mem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;

  logic [7:0]  mem [256];
  int          wait_cfg [4];
  bit          noise;
  logic [31:0] prev_instr;
  int          n_cmp, n_err;

  instr_fetch #(.ADR_W(8), .NBYTES(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc),
    .mem_rd(mem_rd), .mem_adr(mem_adr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] p);
    pc = p;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // call in the first FETCH cycle; walks the expected byte sequence and checks the DONE pulse
  task automatic run_fetch(input logic [7:0] p, input bit chain, input logic [7:0] np);
    logic [31:0] exp_i;
    logic [7:0]  a;
    for (int b = 0; b < 4; b++) begin
      a = p + 8'(b);
      exp_i[8*b +: 8] = mem[a];
    end
    for (int b = 0; b < 4; b++) begin
      a = p + 8'(b);
      for (int w = 0; w <= wait_cfg[b]; w++) begin
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL fetch_mem_rd: got %b want 1", mem_rd); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fetch_busy: got %b want 1", busy); end
        n_cmp++; if (mem_adr !== a) begin n_err++; $display("FAIL fetch_adr: got %h want %h", mem_adr, a); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fetch_valid_early: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== prev_instr) begin n_err++; $display("FAIL fetch_instr_hold: got %h want %h", instr, prev_instr); end
        n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL fetch_error: got %b want 0", error); end
        mem_ready = (w == wait_cfg[b]);
        mem_rdata = mem_ready ? mem[a] : 8'($urandom);
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          pc = 8'($urandom);
        end
        step();
      end
    end
    start = 1'b0;
    mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL done_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr !== exp_i) begin n_err++; $display("FAIL done_instr: got %h want %h", instr, exp_i); end
    n_cmp++; if (opcode !== exp_i[31:26]) begin n_err++; $display("FAIL done_opcode: got %b want %b", opcode, exp_i[31:26]); end
    n_cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL done_idle_bus: got busy=%b mem_rd=%b want 0/0", busy, mem_rd); end
    prev_instr = exp_i;
    if (chain) begin
      pc = np;
      start = 1'b1;
      step();
      start = 1'b0;
    end else begin
      step();
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL pulse_width: got %b want 0", instr_valid); end
      n_cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL post_idle: got busy=%b mem_rd=%b want 0/0", busy, mem_rd); end
    end
  endtask

  task automatic set_waits(input int w0, input int w1, input int w2, input int w3);
    wait_cfg[0] = w0; wait_cfg[1] = w1; wait_cfg[2] = w2; wait_cfg[3] = w3;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    n_cmp++; if ({mem_rd, mem_adr, instr, instr_valid, busy, error} !== 44'd0) begin
      n_err++; $display("FAIL reset_outputs: got rd=%b adr=%h instr=%h v=%b busy=%b err=%b want all 0",
                        mem_rd, mem_adr, instr, instr_valid, busy, error); end
    reset = 1'b1;
    step();
    n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_idle_rd: got %b want 0", mem_rd); end
  endtask

  task automatic test_zero_wait();
    mem[8'h10] = 8'h20; mem[8'h11] = 8'h00; mem[8'h12] = 8'h05; mem[8'h13] = 8'h80;
    set_waits(0, 0, 0, 0);
    noise = 1'b0;
    do_start(8'h10);
    run_fetch(8'h10, 1'b0, 8'h00);
    n_cmp++; if (instr !== 32'h80050020) begin n_err++; $display("FAIL zero_wait_instr: got %h want 80050020", instr); end
    n_cmp++; if (opcode !== 6'b100000) begin n_err++; $display("FAIL zero_wait_opcode: got %b want 100000", opcode); end
  endtask

  task automatic test_wait_states();
    set_waits(3, 3, 3, 3);
    noise = 1'b0;
    do_start(8'h40);
    run_fetch(8'h40, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    set_waits(1, 0, 2, 0);
    noise = 1'b0;
    do_start(8'hFE);
    run_fetch(8'hFE, 1'b0, 8'h00);
  endtask

  task automatic run_timeout(input logic [7:0] p);
    do_start(p);
    mem_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      n_cmp++; if (busy !== 1'b1 || mem_adr !== p) begin
        n_err++; $display("FAIL timeout_wait: got busy=%b adr=%h want 1/%h", busy, mem_adr, p); end
      step();
    end
    n_cmp++; if (error !== 1'b1 || busy !== 1'b0 || mem_rd !== 1'b0) begin
      n_err++; $display("FAIL timeout_err: got err=%b busy=%b rd=%b want 1/0/0", error, busy, mem_rd); end
    n_cmp++; if (instr !== prev_instr || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL timeout_instr: got %h v=%b want %h v=0", instr, instr_valid, prev_instr); end
  endtask

  task automatic test_timeout();
    noise = 1'b0;
    run_timeout(8'h70);
    mem_ready = 1'b1;
    repeat (2) step();
    mem_ready = 1'b0;
    n_cmp++; if (error !== 1'b1 || mem_rd !== 1'b0) begin
      n_err++; $display("FAIL error_sticky: got err=%b rd=%b want 1/0", error, mem_rd); end
    set_waits(14, 0, 2, 14);
    do_start(8'h70);
    run_fetch(8'h70, 1'b0, 8'h00);
    run_timeout(8'h90);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++; if (error !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_clears_error: got err=%b busy=%b want 0/0", error, busy); end
  endtask

  task automatic test_abort();
    logic [7:0] a;
    noise = 1'b0;
    do_start(8'h30);
    for (int b = 0; b < 3; b++) begin
      a = 8'h30 + 8'(b);
      mem_ready = 1'b1;
      mem_rdata = mem[a];
      step();
    end
    n_cmp++; if (mem_adr !== 8'h33) begin n_err++; $display("FAIL abort_pre_adr: got %h want 33", mem_adr); end
    abort = 1'b1; start = 1'b1; pc = 8'h55; mem_ready = 1'b1; mem_rdata = mem[8'h33];
    step();
    abort = 1'b0; start = 1'b0; mem_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: got busy=%b rd=%b want 0/0", busy, mem_rd); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (instr_valid !== 1'b0 || instr !== prev_instr) begin
        n_err++; $display("FAIL abort_no_valid: got v=%b instr=%h want 0/%h", instr_valid, instr, prev_instr); end
      step();
    end
    set_waits(0, 1, 0, 1);
    do_start(8'h30);
    run_fetch(8'h30, 1'b0, 8'h00);
  endtask

  task automatic test_async_reset();
    noise = 1'b0;
    do_start(8'h20);
    mem_ready = 1'b1;
    mem_rdata = mem[8'h20];
    step();
    mem_rdata = mem[8'h21];
    step();
    #3 reset = 1'b0;
    #1;
    n_cmp++; if ({mem_rd, mem_adr, instr, opcode, instr_valid, busy, error} !== 50'd0) begin
      n_err++; $display("FAIL async_reset: got rd=%b adr=%h instr=%h v=%b busy=%b err=%b want all 0",
                        mem_rd, mem_adr, instr, instr_valid, busy, error); end
    #2 reset = 1'b1;
    prev_instr = 32'd0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b0 || mem_rd !== 1'b0) begin
        n_err++; $display("FAIL post_reset_quiet: got v=%b rd=%b want 0/0", instr_valid, mem_rd); end
    end
    mem_ready = 1'b0;
    set_waits(0, 0, 0, 0);
    do_start(8'h21);
    run_fetch(8'h21, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    noise = 1'b0;
    set_waits(0, 0, 0, 0);
    do_start(8'hA0);
    run_fetch(8'hA0, 1'b1, 8'hB3);
    set_waits(2, 0, 0, 1);
    run_fetch(8'hB3, 1'b1, 8'hFD);
    set_waits(0, 0, 0, 0);
    run_fetch(8'hFD, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    bit         started;
    bit         ch;
    logic [7:0] p, nxt;
    started = 1'b0;
    p = 8'($urandom);
    noise = 1'b1;
    for (int i = 0; i < 25; i++) begin
      for (int b = 0; b < 4; b++) wait_cfg[b] = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 4));
      if (!started) do_start(p);
      nxt = 8'($urandom);
      ch = (i < 24) && ($urandom_range(0, 1) == 1);
      run_fetch(p, ch, nxt);
      started = ch;
      p = nxt;
    end
    noise = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    prev_instr = 32'd0;
    noise = 1'b0;
    start = 1'b0; abort = 1'b0; pc = 8'h00; mem_ready = 1'b0; mem_rdata = 8'h00;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_wrap();
    test_timeout();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
